pipelined_register_file: RTL

- Parametrised successor to the processor's 8x16 register file.
- Synchronous single-edge write with configurable write-to-read bypass and an optional hard-wired zero register.
- Registered read outputs with flush and stall control.
- Per-register pending-write scoreboard, so the decode stage can detect RAW hazards.
- Sits between decode (read/reserve) and writeback (write/release).

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_scoreboard.sv | 57 +++++
 rtl/pipelined_register_file.sv | 92 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file types and default geometry, used by decode and
// writeback as well as by the register file itself.
package regfile_pkg;

  localparam int REGFILE_DATA_WIDTH = 16;
  localparam int REGFILE_ADDR_WIDTH = 3;

  typedef logic [REGFILE_DATA_WIDTH-1:0] reg_data_t;
  typedef logic [REGFILE_ADDR_WIDTH-1:0] reg_adr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by a decode-stage
// reserve, cleared by the writeback release, wiped by flush.
module regfile_scoreboard #(
  parameter int ADDR_WIDTH = 3,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  reserve_en,
  input  logic [ADDR_WIDTH-1:0] reserve_adr,
  input  logic                  release_en,
  input  logic [ADDR_WIDTH-1:0] release_adr,
  input  logic [ADDR_WIDTH-1:0] lookup_adr_1,
  input  logic [ADDR_WIDTH-1:0] lookup_adr_2,
  output logic                  busy_1,
  output logic                  busy_2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             fwd_1;
  logic             fwd_2;

  // Reserve is applied after release so a new producer wins over the
  // retiring one when both target the same register in one cycle.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (release_en) busy_d[release_adr] = 1'b0;
      if (reserve_en) busy_d[reserve_adr] = 1'b1;
    end
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign fwd_1 = (BYPASS != 0) && release_en && (release_adr == lookup_adr_1);
  assign fwd_2 = (BYPASS != 0) && release_en && (release_adr == lookup_adr_2);

  assign busy_1 = busy_q[lookup_adr_1] && !fwd_1 &&
                  !((ZERO_REG != 0) && (lookup_adr_1 == '0));
  assign busy_2 = busy_q[lookup_adr_2] && !fwd_2 &&
                  !((ZERO_REG != 0) && (lookup_adr_2 == '0));

endmodule

// File: rtl/pipelined_register_file.sv
// Two-read/one-write register file with registered read ports, optional
// write-to-read forwarding, optional hard-wired zero register and RAW scoreboard.
module pipelined_register_file
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = REGFILE_DATA_WIDTH,
  parameter int ADDR_WIDTH = REGFILE_ADDR_WIDTH,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  stall,
  input  logic [ADDR_WIDTH-1:0] read_adr_1,
  input  logic [ADDR_WIDTH-1:0] read_adr_2,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] write_adr,
  input  logic                  write_en,
  input  logic                  reserve_en,
  input  logic [ADDR_WIDTH-1:0] reserve_adr,
  output logic [DATA_WIDTH-1:0] data_out_1,
  output logic [DATA_WIDTH-1:0] data_out_2,
  output logic                  busy_1,
  output logic                  busy_2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // write_en and reserve_en are single-cycle strobes sampled at every rising
  // edge; there is no backpressure, and stall/flush never block a write.
  logic [DATA_WIDTH-1:0] file_q [DEPTH];
  logic [ADDR_WIDTH-1:0] rd_adr [2];
  logic [DATA_WIDTH-1:0] rd_sel [2];
  logic [DATA_WIDTH-1:0] dout_q [2];
  logic                  write_ok;

  assign write_ok  = write_en && !((ZERO_REG != 0) && (write_adr == '0));
  assign rd_adr[0] = read_adr_1;
  assign rd_adr[1] = read_adr_2;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) file_q[i] <= '0;
    end else if (write_ok) begin
      file_q[write_adr] <= write_data;
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_sel[p] = file_q[rd_adr[p]];
      if ((BYPASS != 0) && write_en && (write_adr == rd_adr[p])) rd_sel[p] = write_data;
      if ((ZERO_REG != 0) && (rd_adr[p] == '0)) rd_sel[p] = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dout_q[0] <= '0;
      dout_q[1] <= '0;
    end else if (flush) begin
      dout_q[0] <= '0;
      dout_q[1] <= '0;
    end else if (!stall) begin
      dout_q[0] <= rd_sel[0];
      dout_q[1] <= rd_sel[1];
    end
  end

  assign data_out_1 = dout_q[0];
  assign data_out_2 = dout_q[1];

  regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BYPASS     (BYPASS),
    .ZERO_REG   (ZERO_REG)
  ) u_scoreboard (
    .clock        (clock),
    .reset_n      (reset_n),
    .flush        (flush),
    .reserve_en   (reserve_en),
    .reserve_adr  (reserve_adr),
    .release_en   (write_en),
    .release_adr  (write_adr),
    .lookup_adr_1 (read_adr_1),
    .lookup_adr_2 (read_adr_2),
    .busy_1       (busy_1),
    .busy_2       (busy_2)
  );

endmodule
